// File: rtl/audio_uart_pkg.sv
// Shared definitions for the UART-to-audio sample path: word widths,
// assembler/pacer state encodings and the byte-pairing helper.
package audio_uart_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BYTE_W   = 8;

  // Byte-pair assembler: waiting for the high byte, or holding it for the low byte.
  typedef enum logic {
    ASM_WAIT_MSB = 1'b0,
    ASM_WAIT_LSB = 1'b1
  } asm_state_e;

  // Output pacer: filling up to the prefill mark, or releasing one sample per period.
  typedef enum logic {
    PACE_PRIME = 1'b0,
    PACE_PLAY  = 1'b1
  } pace_state_e;

  // Samples arrive high byte first.
  function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [BYTE_W-1:0] msb,
                                                      input logic [BYTE_W-1:0] lsb);
    return {msb, lsb};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO. The head word is always visible on rdata_o.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// flush_i empties the FIFO on the next clock edge.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_LVL);
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];
  assign level_o = cnt_q;

  // Reading the head happens before the write, so a full FIFO can take a push
  // into the slot being vacated by a simultaneous pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_sample_scheduler.sv
// Pairs UART bytes into 16-bit samples (high byte first) with a gap watchdog,
// buffers them in a small FIFO and releases one sample per SAMPLE_DIV clocks
// once the FIFO has been prefilled to half depth.
module uart_sample_scheduler
  import audio_uart_pkg::*;
#(
  parameter int SAMPLE_DIV  = 2268,
  parameter int TIMEOUT_CYC = 4096,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          in_clk,
  input  logic                          in_rst_n,
  input  logic                          in_enable,
  input  logic                          in_uart_ready,
  input  logic [BYTE_W-1:0]             in_uart_frame,
  output logic [SAMPLE_W-1:0]           out_sample,
  output logic                          out_sample_valid,
  output logic [$clog2(FIFO_DEPTH):0]   out_fifo_level,
  output logic                          out_playing,
  output logic                          out_underrun,
  output logic                          out_overrun,
  output logic                          out_resync
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [LVL_W-1:0] PREFILL  = LVL_W'(FIFO_DEPTH / 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_CYC);

  // Assembler state
  asm_state_e          asm_q;
  logic [BYTE_W-1:0]   msb_q;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                push_q;
  logic [SAMPLE_W-1:0] push_data_q;
  logic                resync_q;

  // Pacer state
  pace_state_e         pace_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick;
  logic                pop;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                underrun_q;
  logic                overrun_q;

  // FIFO view
  logic [SAMPLE_W-1:0] fifo_head;
  logic [LVL_W-1:0]    fifo_level;
  logic                fifo_full;
  logic                fifo_empty;

  assign gap_d = gap_q + 1'b1;
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // PRIME waits for half a FIFO before the first release; PLAY releases whenever
  // anything is buffered.
  assign pop = tick && ((pace_q == PACE_PLAY) ? !fifo_empty : (fifo_level >= PREFILL));

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (in_clk),
    .rst_ni  (in_rst_n),
    .flush_i (!in_enable),
    .push_i  (push_q),
    .pop_i   (pop),
    .wdata_i (push_data_q),
    .rdata_o (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Byte-pair assembler: latch MSB, watch the gap, issue a push one cycle after the LSB.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      asm_q       <= ASM_WAIT_MSB;
      msb_q       <= '0;
      gap_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      resync_q    <= 1'b0;
    end else if (!in_enable) begin
      asm_q       <= ASM_WAIT_MSB;
      msb_q       <= '0;
      gap_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      resync_q    <= 1'b0;
    end else begin
      push_q   <= 1'b0;
      resync_q <= 1'b0;
      case (asm_q)
        ASM_WAIT_MSB: begin
          if (in_uart_ready) begin
            msb_q <= in_uart_frame;
            gap_q <= '0;
            asm_q <= ASM_WAIT_LSB;
          end
        end
        ASM_WAIT_LSB: begin
          // A byte arriving on the timeout cycle still completes the pair.
          if (in_uart_ready) begin
            push_q      <= 1'b1;
            push_data_q <= pack_sample(msb_q, in_uart_frame);
            asm_q       <= ASM_WAIT_MSB;
          end else if (gap_d == GAP_MAX) begin
            gap_q    <= '0;
            resync_q <= 1'b1;
            asm_q    <= ASM_WAIT_MSB;
          end else begin
            gap_q <= gap_d;
          end
        end
        default: asm_q <= ASM_WAIT_MSB;
      endcase
    end
  end

  // Pacer: free-running period divider plus PRIME/PLAY state and the output sample register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pace_q     <= PACE_PRIME;
      div_q      <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!in_enable) begin
      // out_sample deliberately keeps its last value through a flush.
      pace_q     <= PACE_PRIME;
      div_q      <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      if (pop) begin
        sample_q <= fifo_head;
        valid_q  <= 1'b1;
        pace_q   <= PACE_PLAY;
      end else if (tick && (pace_q == PACE_PLAY)) begin
        underrun_q <= 1'b1;
        pace_q     <= PACE_PRIME;
      end
    end
  end

  // Overrun flag: a completed sample met a full FIFO with no pop to make room.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      overrun_q <= 1'b0;
    end else if (!in_enable) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_q && fifo_full && !pop;
    end
  end

  assign out_sample       = sample_q;
  assign out_sample_valid = valid_q;
  assign out_fifo_level   = fifo_level;
  assign out_playing      = (pace_q == PACE_PLAY);
  assign out_underrun     = underrun_q;
  assign out_overrun      = overrun_q;
  assign out_resync       = resync_q;

endmodule

// File: tb/tb_uart_sample_scheduler.sv
// Bench for uart_sample_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based model.
module tb_uart_sample_scheduler;

  localparam int DIV   = 8;
  localparam int TO    = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        rdy = 1'b0;
  logic [7:0]  frm = 8'h00;

  logic [15:0] sample;
  logic        svalid;
  logic [2:0]  level;
  logic        playing, underrun, overrun, resync;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_sample_scheduler #(
    .SAMPLE_DIV  (DIV),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .in_clk           (clk),
    .in_rst_n         (rst_n),
    .in_enable        (en),
    .in_uart_ready    (rdy),
    .in_uart_frame    (frm),
    .out_sample       (sample),
    .out_sample_valid (svalid),
    .out_fifo_level   (level),
    .out_playing      (playing),
    .out_underrun     (underrun),
    .out_overrun      (overrun),
    .out_resync       (resync)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] q[$];
  bit          have_msb;
  logic [7:0]  m_msb;
  int          gap;
  bit          pend;
  logic [15:0] pend_data;
  int          div;
  bit          play;
  logic [15:0] e_sample;
  bit          e_valid, e_under, e_over, e_resync;
  int          m_L;
  bit          m_tick, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      have_msb = 0; gap = 0; pend = 0; div = 0; play = 0;
      e_sample = 16'h0; e_valid = 0; e_under = 0; e_over = 0; e_resync = 0;
    end else if (!en) begin
      q.delete();
      have_msb = 0; gap = 0; pend = 0; div = 0; play = 0;
      e_valid = 0; e_under = 0; e_over = 0; e_resync = 0;
    end else begin
      m_L    = q.size();
      m_tick = (div == DIV - 1);
      m_pop  = m_tick && (play ? (m_L > 0) : (m_L >= DEPTH / 2));
      e_under = m_tick && play && (m_L == 0);
      e_valid = m_pop;
      e_over  = 0;
      if (m_pop) e_sample = q.pop_front();
      if (pend) begin
        if (m_L < DEPTH || m_pop) q.push_back(pend_data);
        else e_over = 1;
      end
      if (m_tick) play = m_pop;
      div = (div + 1) % DIV;
      pend = 0;
      e_resync = 0;
      if (!have_msb) begin
        if (rdy) begin have_msb = 1; m_msb = frm; gap = 0; end
      end else if (rdy) begin
        pend = 1; pend_data = {m_msb, frm}; have_msb = 0;
      end else begin
        gap++;
        if (gap == TO) begin have_msb = 0; e_resync = 1; end
      end
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    chk("m_sample",   sample,   e_sample);
    chk("m_valid",    svalid,   e_valid);
    chk("m_level",    level,    q.size());
    chk("m_playing",  playing,  play);
    chk("m_underrun", underrun, e_under);
    chk("m_overrun",  overrun,  e_over);
    chk("m_resync",   resync,   e_resync);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input logic [7:0] f);
    rdy = r;
    frm = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pct;
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample",  sample,  16'h0);
    chk("rst_valid",   svalid,  0);
    chk("rst_level",   level,   0);
    chk("rst_playing", playing, 0);
    chk("rst_flags",   {underrun, overrun, resync}, 0);
    rst_n = 1'b1;

    // Pairing and prefill
    cyc(1, 8'h12); cyc(0, 0); cyc(0, 0); cyc(1, 8'h34);
    chk("t1_level_lat", level, 0);
    cyc(0, 0);
    chk("t1_level", level, 1);
    chk("t1_noout", {svalid, playing}, 0);
    cyc(1, 8'h56); cyc(1, 8'h78); cyc(0, 0);
    chk("t2_level2", level, 2);
    chk("t2_prime", playing, 0);
    repeat (8) cyc(0, 0);
    chk("t2_s1", sample, 16'h1234);
    chk("t2_v1", svalid, 1);
    chk("t2_play", playing, 1);
    chk("t2_lvl1", level, 1);
    repeat (8) cyc(0, 0);
    chk("t2_s2", sample, 16'h5678);
    chk("t2_v2", svalid, 1);
    chk("t3_lvl0", level, 0);
    repeat (8) cyc(0, 0);
    chk("t3_under", underrun, 1);
    chk("t3_hold", sample, 16'h5678);
    chk("t3_prime", playing, 0);

    // Gap timeout
    cyc(1, 8'hAB);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0);
      if (i == 14) chk("t4_noresync", resync, 0);
    end
    chk("t4_resync", resync, 1);
    cyc(1, 8'h9A);
    chk("t4_pulse1", resync, 0);
    cyc(1, 8'hBC); cyc(0, 0);
    chk("t4_level", level, 1);

    // Reset mid-pair
    cyc(1, 8'hFF); cyc(0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_sample", sample, 16'h0);
    chk("t6_level", level, 0);
    chk("t6_all", {svalid, playing, underrun, overrun, resync}, 0);
    cyc(0, 0); cyc(0, 0);
    rst_n = 1'b1;
    cyc(1, 8'h00); cyc(1, 8'h01); cyc(1, 8'h00); cyc(1, 8'h02);
    repeat (4) cyc(0, 0);
    chk("t6_s0001", sample, 16'h0001);
    chk("t6_valid", svalid, 1);

    // Flush holds out_sample
    en = 1'b0;
    cyc(0, 0);
    chk("fl_hold", sample, 16'h0001);
    chk("fl_level", level, 0);
    chk("fl_play", playing, 0);
    en = 1'b1;

    // Overrun, then push coincident with a pop
    cyc(0, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(1, 8'h10 + 8'(i));
      if (i == 6) begin
        chk("t5_first", sample, 16'h1011);
        chk("t5_lvl2", level, 2);
      end
      if (i == 12) begin
        chk("t5_over", overrun, 1);
        chk("t5_lvl4", level, 4);
      end
    end
    cyc(0, 0);
    chk("t5_nover", overrun, 0);
    chk("t5_lvl4b", level, 4);
    chk("t5_s2", sample, 16'h1213);
    chk("t5_v", svalid, 1);

    // Randomized traffic
    for (int blk = 0; blk < 24; blk++) begin
      case ($urandom_range(0, 4))
        0:       pct = 5;
        1:       pct = 20;
        2:       pct = 30;
        3:       pct = 60;
        default: pct = 95;
      endcase
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 1999) == 0) begin
          rst_n = 1'b0;
          cyc(0, 0);
          cyc(0, 0);
          rst_n = 1'b1;
        end
        en = ($urandom_range(0, 299) != 0);
        cyc($urandom_range(0, 99) < pct, 8'($urandom));
      end
    end
    en = 1'b1;
    repeat (4) cyc(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
